// File: rtl/prim_rsp_router.sv
// Response return path of an N:1 arbiter: tracks granted requester indices in order, steers responses back 1:N.
// Latency: 0 cycles, rsp_valid_i/rsp_ready_i to per-port outputs; outstanding_o/err_o registered (+1 cycle).
// Backpressure: head port's ready stalls rsp_ready_o; req_ready_o drops when tracking FIFO is full.

module prim_rsp_router_fifo #(
    parameter int Depth = 4,
    parameter int W     = 3,
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [W-1:0]    push_dat,
    input  logic            pop,
    output logic [W-1:0]    head_dat,
    output logic [CntW-1:0] count,
    output logic            full,
    output logic            empty
);
    logic [W-1:0]    mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full     = (count == CntW'(Depth));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module prim_rsp_router #(
    parameter int N     = 8,
    parameter int DW    = 32,
    parameter int Depth = 4,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_fire_i,
    input  logic [IdxW-1:0] req_idx_i,
    output logic            req_ready_o,
    input  logic            rsp_valid_i,
    input  logic [DW-1:0]   rsp_data_i,
    output logic            rsp_ready_o,
    output logic [N-1:0]    rsp_valid_o,
    output logic [DW-1:0]   rsp_data_o [N],
    input  logic [N-1:0]    rsp_ready_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            err_o
);
    localparam logic [IdxW:0] NLim = (IdxW + 1)'(N);

    logic [IdxW-1:0] head;
    logic [CntW-1:0] count;
    logic            full;
    logic            empty;
    logic            head_ok;
    logic            pop;
    logic [N-1:0]    hit;
    logic            err;

    prim_rsp_router_fifo #(
        .Depth (Depth),
        .W     (IdxW)
    ) u_idx_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .push     (req_fire_i),
        .push_dat (req_idx_i),
        .pop      (pop),
        .head_dat (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Indices >= N can only appear for non-power-of-2 N; such responses are sunk.
    assign head_ok = ({1'b0, head} < NLim);
    assign pop     = rsp_valid_i && rsp_ready_o && !empty;

    always_comb begin
        hit         = '0;
        rsp_valid_o = '0;
        for (int k = 0; k < N; k++) begin
            hit[k]         = (head == IdxW'(k));
            rsp_valid_o[k] = rsp_valid_i && !empty && head_ok && hit[k];
            rsp_data_o[k]  = rsp_data_i;
        end
        rsp_ready_o = 1'b1;
        if (!empty && head_ok) rsp_ready_o = |(hit & rsp_ready_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err <= 1'b0;
        end else if ((req_fire_i && full) || (rsp_valid_i && empty) || (pop && !head_ok)) begin
            err <= 1'b1;
        end
    end

    assign req_ready_o   = !full;
    assign outstanding_o = count;
    assign err_o         = err;
endmodule

// File: tb/tb_prim_rsp_router.sv
// Bench for prim_rsp_router: vector table plus hand sequences, port routing checked by a scoreboard.
module tb_prim_rsp_router;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // main instance: N=8, Depth=4
    logic        fire = 0;
    logic [2:0]  idx = 0;
    logic        rv = 0;
    logic [31:0] rdata = 0;
    logic [7:0]  rrdy = 8'hFF;
    logic        req_ready, rsp_ready, err;
    logic [7:0]  vout;
    logic [31:0] dout [8];
    logic [2:0]  outs;

    prim_rsp_router #(.N(8), .DW(32), .Depth(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_fire_i(fire), .req_idx_i(idx), .req_ready_o(req_ready),
        .rsp_valid_i(rv), .rsp_data_i(rdata), .rsp_ready_o(rsp_ready), .rsp_valid_o(vout),
        .rsp_data_o(dout), .rsp_ready_i(rrdy), .outstanding_o(outs), .err_o(err));

    // wrap instance: N=8, Depth=3
    logic        w_fire = 0;
    logic [2:0]  w_idx = 0;
    logic        w_rv = 0;
    logic [31:0] w_data = 0;
    logic [7:0]  w_rrdy = 8'hFF;
    logic        w_req_ready, w_rsp_ready, w_err;
    logic [7:0]  w_vout;
    logic [31:0] w_dout [8];
    logic [1:0]  w_outs;

    prim_rsp_router #(.N(8), .DW(32), .Depth(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_fire_i(w_fire), .req_idx_i(w_idx), .req_ready_o(w_req_ready),
        .rsp_valid_i(w_rv), .rsp_data_i(w_data), .rsp_ready_o(w_rsp_ready), .rsp_valid_o(w_vout),
        .rsp_data_o(w_dout), .rsp_ready_i(w_rrdy), .outstanding_o(w_outs), .err_o(w_err));

    // N=1 instance
    logic       a_fire = 0;
    logic [0:0] a_idx = 0;
    logic       a_rv = 0;
    logic [7:0] a_data = 0;
    logic [0:0] a_rrdy = 1'b1;
    logic       a_req_ready, a_rsp_ready, a_err;
    logic [0:0] a_vout;
    logic [7:0] a_dout [1];
    logic [1:0] a_outs;

    prim_rsp_router #(.N(1), .DW(8), .Depth(2)) dut_n1 (
        .clk_i(clk), .rst_ni(rst_n), .req_fire_i(a_fire), .req_idx_i(a_idx), .req_ready_o(a_req_ready),
        .rsp_valid_i(a_rv), .rsp_data_i(a_data), .rsp_ready_o(a_rsp_ready), .rsp_valid_o(a_vout),
        .rsp_data_o(a_dout), .rsp_ready_i(a_rrdy), .outstanding_o(a_outs), .err_o(a_err));

    // N=5 instance
    logic       b_fire = 0;
    logic [2:0] b_idx = 0;
    logic       b_rv = 0;
    logic [7:0] b_data = 0;
    logic [4:0] b_rrdy = 5'h1F;
    logic       b_req_ready, b_rsp_ready, b_err;
    logic [4:0] b_vout;
    logic [7:0] b_dout [5];
    logic [1:0] b_outs;

    prim_rsp_router #(.N(5), .DW(8), .Depth(2)) dut_n5 (
        .clk_i(clk), .rst_ni(rst_n), .req_fire_i(b_fire), .req_idx_i(b_idx), .req_ready_o(b_req_ready),
        .rsp_valid_i(b_rv), .rsp_data_i(b_data), .rsp_ready_o(b_rsp_ready), .rsp_valid_o(b_vout),
        .rsp_data_o(b_dout), .rsp_ready_i(b_rrdy), .outstanding_o(b_outs), .err_o(b_err));

    typedef struct {
        logic        fire;
        logic [2:0]  idx;
        logic        rv;
        logic [31:0] data;
        logic [7:0]  rrdy;
        logic        e_req_rdy;
        logic        e_rsp_rdy;
        logic [7:0]  e_v;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs [19];
    logic [2:0] sb  [$];
    logic [2:0] sb3 [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_observe();
        logic [2:0] e;
        if (vout != 8'h00) begin
            if (sb.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL sb_unexpected: got vout 0x%0h expected no response", vout);
            end else begin
                e = sb[0];
                chk("sb_route", 64'(vout), 64'(8'h01 << e));
                chk("sb_data", 64'(dout[e]), 64'(rdata));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    endtask

    task automatic apply_vec(input vec_t v, input int n);
        fire = v.fire; idx = v.idx; rv = v.rv; rdata = v.data; rrdy = v.rrdy;
        #2;
        chk($sformatf("v%0d_req_ready", n), 64'(req_ready), 64'(v.e_req_rdy));
        chk($sformatf("v%0d_rsp_ready", n), 64'(rsp_ready), 64'(v.e_rsp_rdy));
        chk($sformatf("v%0d_valid_o", n), 64'(vout), 64'(v.e_v));
        chk($sformatf("v%0d_outstanding", n), 64'(outs), 64'(v.e_out));
        chk($sformatf("v%0d_err", n), 64'(err), 64'(v.e_err));
        sb_observe();
        if (v.fire && v.e_req_rdy) sb.push_back(v.idx);
        step();
    endtask

    task automatic do_reset();
        fire = 0; rv = 0; rrdy = 8'hFF;
        rst_n = 0;
        step();
        rst_n = 1;
        sb.delete();
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_ready", 64'(rsp_ready), 64'd1);
        chk("rst_valid_o", 64'(vout), 64'd0);
        chk("rst_outstanding", 64'(outs), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        step();
    endtask

    initial begin
        //                 fire idx rv data          rrdy   rrdy_o rsp_o v      out  err
        vecs[0]  = '{1'b1, 3'd2, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd1, 1'b0};
        vecs[2]  = '{1'b1, 3'd5, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd2, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 1'b1, 32'hD000_0000, 8'hFF, 1'b1, 1'b1, 8'h04, 3'd3, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 1'b1, 32'hD000_0001, 8'hFF, 1'b1, 1'b1, 8'h01, 3'd2, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 1'b1, 32'hD000_0002, 8'hFF, 1'b1, 1'b1, 8'h20, 3'd1, 1'b0};
        vecs[6]  = '{1'b0, 3'd0, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[7]  = '{1'b1, 3'd1, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[8]  = '{1'b1, 3'd2, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd1, 1'b0};
        vecs[9]  = '{1'b1, 3'd3, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd2, 1'b0};
        vecs[10] = '{1'b1, 3'd4, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd3, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 1'b1, 32'hD000_0003, 8'hFF, 1'b0, 1'b1, 8'h02, 3'd4, 1'b0};
        vecs[12] = '{1'b1, 3'd6, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd3, 1'b0};
        vecs[13] = '{1'b1, 3'd7, 1'b1, 32'hD000_0004, 8'hFF, 1'b0, 1'b1, 8'h04, 3'd4, 1'b0};
        vecs[14] = '{1'b0, 3'd0, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd3, 1'b1};
        vecs[15] = '{1'b0, 3'd0, 1'b1, 32'hD000_0005, 8'hFF, 1'b1, 1'b1, 8'h08, 3'd3, 1'b1};
        vecs[16] = '{1'b0, 3'd0, 1'b1, 32'hD000_0006, 8'hFF, 1'b1, 1'b1, 8'h10, 3'd2, 1'b1};
        vecs[17] = '{1'b0, 3'd0, 1'b1, 32'hD000_0007, 8'hFF, 1'b1, 1'b1, 8'h40, 3'd1, 1'b1};
        vecs[18] = '{1'b0, 3'd0, 1'b0, 32'h0,       8'hFF, 1'b1, 1'b1, 8'h00, 3'd0, 1'b1};

        step();
        do_reset();

        for (int i = 0; i < 19; i++) apply_vec(vecs[i], i);
        chk("table_sb_drained", 64'(sb.size()), 64'd0);

        // head idx 3 stalled for 5 cycles by its own ready
        do_reset();
        fire = 1; idx = 3'd3;
        sb.push_back(3'd3);
        step();
        fire = 0; rv = 1; rdata = 32'hBEEF_0003; rrdy = 8'hF7;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("stall_rsp_ready", 64'(rsp_ready), 64'd0);
            chk("stall_valid_o", 64'(vout), 64'h08);
            chk("stall_outstanding", 64'(outs), 64'd1);
            sb_observe();
            step();
        end
        rrdy = 8'hFF;
        #2;
        chk("release_rsp_ready", 64'(rsp_ready), 64'd1);
        sb_observe();
        step();
        rv = 0;
        #2;
        chk("release_outstanding", 64'(outs), 64'd0);
        chk("release_err", 64'(err), 64'd0);
        chk("release_sb_drained", 64'(sb.size()), 64'd0);
        step();

        // orphan response on empty FIFO
        rv = 1; rdata = 32'h0BAD_0BAD;
        #2;
        chk("orphan_rsp_ready", 64'(rsp_ready), 64'd1);
        chk("orphan_valid_o", 64'(vout), 64'd0);
        step();
        rv = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("orphan_err_sticky", 64'(err), 64'd1);
            step();
        end

        // reset mid-operation discards outstanding entries
        fire = 1; idx = 3'd4;
        step();
        fire = 0;
        do_reset();

        // wrap-around at Depth=3: push i and respond to i-1 in the same cycle
        for (int i = 0; i <= 10; i++) begin
            w_fire = (i < 10);
            w_idx  = 3'(i % 8);
            w_rv   = (i > 0);
            w_data = 32'hC000_0000 + 32'(i);
            #2;
            chk("wrap_count_le3", 64'(w_outs <= 2'd3), 64'd1);
            chk("wrap_req_ready", 64'(w_req_ready), 64'd1);
            if (w_rv) begin
                if (sb3.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL wrap_sb_empty: got vout 0x%0h expected a queued entry", w_vout);
                end else begin
                    chk("wrap_route", 64'(w_vout), 64'(8'h01 << sb3[0]));
                    chk("wrap_data", 64'(w_dout[sb3[0]]), 64'(w_data));
                    if (w_rsp_ready) void'(sb3.pop_front());
                end
            end
            if (w_fire && w_req_ready) sb3.push_back(w_idx);
            step();
        end
        w_fire = 0; w_rv = 0;
        #2;
        chk("wrap_outstanding_end", 64'(w_outs), 64'd0);
        chk("wrap_err", 64'(w_err), 64'd0);
        step();

        // N=1 routing
        a_fire = 1; a_idx = 1'b0;
        step();
        a_fire = 0; a_rv = 1; a_data = 8'h5A;
        #2;
        chk("n1_valid_o", 64'(a_vout), 64'd1);
        chk("n1_data", 64'(a_dout[0]), 64'h5A);
        chk("n1_rsp_ready", 64'(a_rsp_ready), 64'd1);
        step();
        a_rv = 0;
        #2;
        chk("n1_outstanding", 64'(a_outs), 64'd0);
        chk("n1_err", 64'(a_err), 64'd0);
        step();

        // N=5 with out-of-range index 6: sunk, pop still occurs
        b_fire = 1; b_idx = 3'd6;
        step();
        b_fire = 0; b_rv = 1; b_data = 8'hA5;
        #2;
        chk("n5_valid_o", 64'(b_vout), 64'd0);
        chk("n5_rsp_ready", 64'(b_rsp_ready), 64'd1);
        chk("n5_outstanding_pre", 64'(b_outs), 64'd1);
        chk("n5_err_pre", 64'(b_err), 64'd0);
        step();
        b_rv = 0;
        #2;
        chk("n5_outstanding", 64'(b_outs), 64'd0);
        chk("n5_err", 64'(b_err), 64'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/prim_rsp_router.md
# prim_rsp_router

Response-return half of a fixed-priority N:1 request arbiter. Records the requester index of every request accepted through the arbiter in an in-order tracking FIFO, then steers each returning response to the originating requester's port, 1:N. Sits between a shared downstream target (bus slave, memory) and the N requesters whose requests the arbiter merged. Responses return strictly in request order.

## Interface

Parameters:
- N, 8, number of requester ports; must be at least 1.
- DW, 32, response data width.
- Depth, 4, maximum outstanding requests; must be at least 1; need not be a power of 2.
- IdxW, derived, max(1, $clog2(N)).
- CntW, derived, $clog2(Depth+1).

Ports (one clock; reset is synchronous and active-low):
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_ni, input, 1, synchronous active-low reset.
- req_fire_i, input, 1, request accepted upstream this cycle (arbiter valid & ready).
- req_idx_i, input, IdxW, index of the requester granted this cycle.
- req_ready_o, output, 1, tracking FIFO not full; upstream ANDs this into the arbiter ready.
- rsp_valid_i, input, 1, response from target.
- rsp_data_i, input, DW, response payload.
- rsp_ready_o, output, 1, response accepted this cycle.
- rsp_valid_o, output, N, per-requester response valid; one-hot or zero.
- rsp_data_o, output, DW x N (unpacked [N]), per-requester payload.
- rsp_ready_i, input, N, per-requester ready.
- outstanding_o, output, CntW, current FIFO occupancy.
- err_o, output, 1, sticky protocol-error flag.

## Operation

- State: index FIFO (Depth x IdxW), write pointer, read pointer, count, err flag. Pointers wrap from Depth-1 to 0.
- Push: req_fire_i && req_ready_o writes req_idx_i at the write pointer and advances it.
- req_ready_o = (count != Depth). It depends only on registered state and has no combinational path from the response side.
- Head: head = fifo[rd_ptr], valid when count != 0.
- Routing (combinational): rsp_valid_o[k] = rsp_valid_i && count != 0 && head == k && head < N.
- rsp_data_o[k] = rsp_data_i for all k (broadcast). Consumers qualify it with rsp_valid_o.
- rsp_ready_o = rsp_ready_i[head] when count != 0 and head < N. It is 1 otherwise (sink mode).
- Pop: rsp_valid_i && rsp_ready_o && count != 0 advances the read pointer.
- Count: count += push - pop. Simultaneous push and pop leave count unchanged.
- Errors set err_o; it is cleared only by reset. Each error case is sunk so it cannot deadlock:
  - req_fire_i while full: push ignored.
  - rsp_valid_i while count == 0: response sunk, no pop.
  - Popped head >= N: response sunk, pop still occurs.
- No bypass: an entry pushed in cycle t is not visible as head until t+1.

## Timing

- Reset (rst_ni low at an edge):
  - Pointers, count and err_o go to 0.
  - Next cycle: req_ready_o=1, rsp_valid_o=0, outstanding_o=0, err_o=0.
  - rsp_ready_o=1 (empty, so sink mode).
- Reset mid-operation discards all outstanding entries. Responses still in flight then count as orphans and set err_o.
- Response latency through the block is 0 cycles, combinational from rsp_valid_i/rsp_ready_i.
- Earliest legal response is the cycle after its request is accepted.
- Full with a simultaneous pop: req_ready_o is still 0 that cycle and the push is blocked. Ready rises the next cycle.
- outstanding_o and err_o are registered and update the cycle after the event.
- Downstream handshake: rsp_valid_i/rsp_data_i stay stable while rsp_ready_o is low. The block never drops a response that is stalled by rsp_ready_i.

## Test plan

- Reset, then three pushes with idx 2, 0, 5 in consecutive cycles, then responses D0..D2 with all rsp_ready_i=1 -> rsp_valid_o = 0x04, 0x01, 0x20 in order; data matches; outstanding_o goes 1,2,3 then down to 0; err_o=0.
- Depth=4: fill 4 entries -> req_ready_o=0; push plus pop in the same cycle -> push rejected and err_o=1 only if req_fire_i was asserted; the cycle after the pop, req_ready_o=1.
- Head idx 3 with rsp_ready_i[3]=0 for 5 cycles -> rsp_ready_o=0 and rsp_valid_o=0x08 held; rsp_ready_i[3] rises -> pop and outstanding_o decrements.
- rsp_valid_i with empty FIFO -> rsp_ready_o=1, rsp_valid_o=0, err_o=1 next cycle and remaining 1 until rst_ni low.
- Wrap-around: 10 push/pop pairs at Depth=3 with idx sequence 0..7,0,1 -> every response lands on the matching port; count never exceeds 3.
- N=1: push idx 0 and respond -> rsp_valid_o[0]=1; N=5 with push idx 6 and respond -> sunk, err_o=1.
